// File: rtl/fifo_sync_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_ext_pkg
// Brief    : Shared read-mode constants and operation encoding for the FIFO.
// Revision : 1.0
// ============================================================================
package fifo_sync_ext_pkg;

  localparam int c_FWFT_OFF = 0;
  localparam int c_FWFT_ON  = 1;

  // Encoded as {write accepted, read accepted}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RDWR = 2'b11
  } fifo_op_e;

endpackage
`default_nettype wire

// File: rtl/fifo_sync_ext_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_ext_if
// Brief    : Write/read handshake and status bundle of the synchronous FIFO.
// Revision : 1.0
// ============================================================================
interface fifo_sync_ext_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 3
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_en;
  logic                  rd_val;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [CNT_W-1:0]      count;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  wr_ready, rd_val, rd_data, count, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output wr_ready, rd_val, rd_data, count, almost_full, almost_empty, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_ext_wrap_ptr.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_ext_wrap_ptr
// Brief    : Ring pointer with increment enable, sync clear and explicit wrap.
// Revision : 1.0
// ============================================================================
module fifo_sync_ext_wrap_ptr
  import fifo_sync_ext_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             i_clr,
  input  wire logic             i_inc,
  output logic      [PTR_W-1:0] o_ptr
);

  // Depth need not be a power of two, so the wrap point is compared explicitly
  localparam logic [PTR_W-1:0] c_LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fifo_sync_ext.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_ext
// Brief    : Single-clock FIFO with concurrent read/write, any depth, selectable
//            registered or show-ahead read, occupancy, level and sticky flags.
// Revision : 1.0
// ============================================================================
module fifo_sync_ext
  import fifo_sync_ext_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FWFT       = c_FWFT_OFF,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input wire logic          clk,
  input wire logic          reset_n,
  fifo_sync_ext_if.slave    bus
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_ext: FIFO_DEPTH must be at least 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > FIFO_DEPTH)) begin : g_bad_af
    $error("fifo_sync_ext: AF_LEVEL must lie in 1..FIFO_DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > FIFO_DEPTH - 1)) begin : g_bad_ae
    $error("fifo_sync_ext: AE_LEVEL must lie in 0..FIFO_DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic [c_PTR_W-1:0]    w_head;
  logic [c_PTR_W-1:0]    w_tail;
  logic                  w_wr_ready;
  logic                  w_rd_val;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  fifo_op_e              w_op;

  // Handshake status comes from the count alone, never from same-cycle requests
  assign w_wr_ready = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_rd_val   = (r_count != '0);
  assign w_wr_acc   = reset_n & ~bus.flush & bus.wr_en & w_wr_ready;
  assign w_rd_acc   = reset_n & ~bus.flush & bus.rd_en & w_rd_val;
  assign w_op       = fifo_op_e'({w_wr_acc, w_rd_acc});

  fifo_sync_ext_wrap_ptr #(
    .DEPTH (FIFO_DEPTH)
  ) u_head_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (bus.flush),
    .i_inc   (w_rd_acc),
    .o_ptr   (w_head)
  );

  fifo_sync_ext_wrap_ptr #(
    .DEPTH (FIFO_DEPTH)
  ) u_tail_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (bus.flush),
    .i_inc   (w_wr_acc),
    .o_ptr   (w_tail)
  );

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_tail] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (bus.flush) begin
      r_count <= '0;
    end else begin
      case (w_op)
        OP_WR:   r_count <= r_count + CNT_W'(1);
        OP_RD:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en && !w_wr_ready) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd_en && !w_rd_val) begin
        r_underflow <= 1'b1;
      end
    end
  end

  if (FWFT == c_FWFT_OFF) begin : g_registered_read
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Flush leaves the last delivered word in place
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_rd_data <= '0;
      end else if (w_rd_acc) begin
        r_rd_data <= r_mem[w_head];
      end
    end

    assign bus.rd_data = r_rd_data;
  end else begin : g_show_ahead_read
    assign bus.rd_data = w_rd_val ? r_mem[w_head] : '0;
  end

  assign bus.wr_ready     = w_wr_ready;
  assign bus.rd_val       = w_rd_val;
  assign bus.count        = r_count;
  assign bus.almost_full  = (r_count >= CNT_W'(AF_LEVEL));
  assign bus.almost_empty = (r_count <= CNT_W'(AE_LEVEL));
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync_ext
// Brief    : Scoreboard bench driving a registered-read and a show-ahead FIFO
//            with the same stimulus against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_fifo_sync_ext;

  localparam int c_DEPTH = 5;
  localparam int c_DW    = 8;
  localparam int c_CW    = $clog2(c_DEPTH + 1);
  localparam int c_AF    = 4;
  localparam int c_AE    = 1;

  typedef struct {
    int cnt;
    bit ovf;
    bit unf;
    bit rd0;
    int front;
  } stat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [c_DW-1:0] wr_data = '0;

  fifo_sync_ext_if #(.DATA_WIDTH(c_DW), .CNT_W(c_CW)) bus0 ();
  fifo_sync_ext_if #(.DATA_WIDTH(c_DW), .CNT_W(c_CW)) bus1 ();

  assign bus0.flush = flush;   assign bus1.flush = flush;
  assign bus0.wr_en = wr_en;   assign bus1.wr_en = wr_en;
  assign bus0.rd_en = rd_en;   assign bus1.rd_en = rd_en;
  assign bus0.wr_data = wr_data; assign bus1.wr_data = wr_data;

  fifo_sync_ext #(.DATA_WIDTH(c_DW), .FIFO_DEPTH(c_DEPTH), .FWFT(0),
                  .AF_LEVEL(c_AF), .AE_LEVEL(c_AE)) dut_reg (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave));

  fifo_sync_ext #(.DATA_WIDTH(c_DW), .FIFO_DEPTH(c_DEPTH), .FWFT(1),
                  .AF_LEVEL(c_AF), .AE_LEVEL(c_AE)) dut_sa (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int    mq[$];
  bit    m_ovf = 1'b0;
  bit    m_unf = 1'b0;
  bit    m_rd0 = 1'b1;
  int    exp_q0[$];
  int    exp_q1[$];
  stat_t stat_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One cycle of stimulus; the model advances to the post-edge state
  task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit f, input bit rn);
    stat_t s;
    bit    wa;
    bit    ra;
    int    v;
    @(posedge clk);
    #1;
    wr_en = w; wr_data = d; rd_en = r; flush = f; reset_n = rn;
    if (!rn) begin
      mq.delete(); m_ovf = 0; m_unf = 0; m_rd0 = 1;
    end else if (f) begin
      mq.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      wa = w && (mq.size() < c_DEPTH);
      ra = r && (mq.size() > 0);
      if (w && !wa) m_ovf = 1;
      if (r && !ra) m_unf = 1;
      if (ra) begin
        v = mq.pop_front();
        exp_q0.push_back(v);
        exp_q1.push_back(v);
        m_rd0 = 0;
      end
      if (wa) mq.push_back(int'(d));
    end
    s.cnt = mq.size(); s.ovf = m_ovf; s.unf = m_unf; s.rd0 = m_rd0;
    s.front = (mq.size() > 0) ? mq[0] : 0;
    stat_q.push_back(s);
  endtask

  task automatic check_status(input string tag, input stat_t s, input logic [c_CW-1:0] cnt,
                              input logic wrdy, input logic rval, input logic af,
                              input logic ae, input logic ovf, input logic unf);
    chk({tag, "_count"}, 32'(cnt), 32'(s.cnt));
    chk({tag, "_wr_ready"}, 32'(wrdy), 32'(s.cnt < c_DEPTH));
    chk({tag, "_rd_val"}, 32'(rval), 32'(s.cnt != 0));
    chk({tag, "_almost_full"}, 32'(af), 32'(s.cnt >= c_AF));
    chk({tag, "_almost_empty"}, 32'(ae), 32'(s.cnt <= c_AE));
    chk({tag, "_overflow"}, 32'(ovf), 32'(s.ovf));
    chk({tag, "_underflow"}, 32'(unf), 32'(s.unf));
  endtask

  // Monitor: compares post-edge status and any data the DUTs present
  bit armed = 1'b0;
  bit pend0 = 1'b0;
  always @(negedge clk) begin
    stat_t s;
    int    e;
    if (pend0) begin
      if (exp_q0.size() == 0) begin
        chk("reg_unexpected_read", 32'(bus0.rd_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q0.pop_front();
        chk("reg_rd_data", 32'(bus0.rd_data), 32'(e));
      end
    end
    if (armed) begin
      s = stat_q.pop_front();
      check_status("reg", s, bus0.count, bus0.wr_ready, bus0.rd_val, bus0.almost_full,
                   bus0.almost_empty, bus0.overflow, bus0.underflow);
      check_status("sa", s, bus1.count, bus1.wr_ready, bus1.rd_val, bus1.almost_full,
                   bus1.almost_empty, bus1.overflow, bus1.underflow);
      if (s.rd0) chk("reg_rd_data_zero", 32'(bus0.rd_data), 32'd0);
      chk("sa_rd_data_head", 32'(bus1.rd_data), 32'(s.front));
    end
    pend0 = rd_en && (bus0.rd_val === 1'b1) && reset_n && !flush;
    if (rd_en && (bus1.rd_val === 1'b1) && reset_n && !flush) begin
      if (exp_q1.size() == 0) begin
        chk("sa_unexpected_read", 32'(bus1.rd_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q1.pop_front();
        chk("sa_rd_data", 32'(bus1.rd_data), 32'(e));
      end
    end
    armed = (stat_q.size() != 0);
  end

  initial begin
    drive(0, 8'h00, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 1);
    // Fill to full, overflow attempt, drain in order
    for (int i = 0; i < 6; i++) drive(1, 8'(8'h11 + i), 0, 0, 1);
    for (int i = 0; i < 5; i++) drive(0, 8'h00, 1, 0, 1);
    drive(0, 8'h00, 0, 1, 1);
    // Fill 3 then sustained simultaneous read/write across wraps
    for (int i = 0; i < 3; i++) drive(1, 8'(8'h21 + i), 0, 0, 1);
    for (int i = 0; i < 10; i++) drive(1, 8'(8'h30 + i), 1, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 8'h00, 1, 0, 1);
    // Empty with read+write: write only; then underflow stays until flush
    drive(1, 8'hA5, 1, 0, 1);
    drive(0, 8'h00, 0, 0, 1);
    drive(0, 8'h00, 1, 0, 1);
    drive(0, 8'h00, 1, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 8'h00, 0, 0, 1);
    drive(0, 8'h00, 0, 1, 1);
    // Show-ahead visibility without rd_en
    drive(1, 8'h3C, 0, 0, 1);
    drive(0, 8'h00, 0, 0, 1);
    drive(0, 8'h00, 1, 0, 1);
    // Flush at count 4 with a concurrent write
    for (int i = 0; i < 4; i++) drive(1, 8'(8'h40 + i), 0, 0, 1);
    drive(1, 8'h99, 0, 1, 1);
    drive(0, 8'h00, 0, 0, 1);
    // Reset at count 3 with a concurrent read
    for (int i = 0; i < 3; i++) drive(1, 8'(8'h50 + i), 0, 0, 1);
    drive(0, 8'h00, 1, 0, 0);
    drive(0, 8'h00, 0, 0, 1);
    // Randomised traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 59) == 0), ($urandom_range(0, 119) != 0));
    end
    drive(0, 8'h00, 0, 0, 1);
    drive(0, 8'h00, 0, 0, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("reg_expected_reads_drained", 32'(exp_q0.size()), 32'd0);
    chk("sa_expected_reads_drained", 32'(exp_q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
